// File: rtl/dmem_ctrl.sv
// MEM-stage data memory sequencer: one load/store at a time over req/gnt/rvalid, word-crossing accesses split in two beats.
// Latency 3 cycles aligned (5 split, 1 illegal) plus bus waits; stalls the pipeline until rsp_valid, no timeout.
module dmem_ctrl #(
  parameter int DW       = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [2:0]    func3,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic          rsp_valid,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [DW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_mask,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ0 = 3'd1;
  localparam logic [2:0] S_RSP0 = 3'd2;
  localparam logic [2:0] S_REQ1 = 3'd3;
  localparam logic [2:0] S_RSP1 = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state;
  logic          op_we;
  logic [2:0]    op_f3;
  logic [1:0]    op_off;
  logic          op_split;
  logic [3:0]    op_mask_hi;
  logic [DW-1:0] op_wdata_hi;
  logic [DW-1:0] op_addr1;
  logic [DW-1:0] lo_q;

  logic [7:0]    in_base;
  logic [7:0]    in_mask;
  logic [63:0]   in_data;
  logic          in_split;
  logic          in_size_ok;
  logic          in_legal;
  logic [DW-1:0] in_addr0;

  logic [55:0]   ld_word;
  logic [31:0]   ld_sh;
  logic [DW-1:0] ld_result;

  // Decode the presented op directly from the pipeline inputs so beat 0 can launch on the accept edge.
  always_comb begin
    in_base = 8'h0F;
    case (func3[1:0])
      2'b00:   in_base = 8'h01;
      2'b01:   in_base = 8'h03;
      default: in_base = 8'h0F;
    endcase
    in_mask  = in_base << addr[1:0];
    in_data  = {32'h0, wdata} << {addr[1:0], 3'b000};
    in_split = |in_mask[7:4];
    in_addr0 = {addr[DW-1:2], 2'b00};
    in_size_ok = 1'b0;
    case (func3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: in_size_ok = 1'b1;
      default:                                in_size_ok = 1'b0;
    endcase
    in_legal = in_size_ok && !(req_we && func3[2]) && !(in_split && !SPLIT_EN);
  end

  // The beat completing now is merged with the buffered low word; bytes above 55 are never addressable.
  always_comb begin
    ld_word = (state == S_RSP1) ? {bus_rdata[23:0], lo_q} : {24'h0, bus_rdata};
    ld_sh   = ld_word[31:0];
    case (op_off)
      2'd0: ld_sh = ld_word[31:0];
      2'd1: ld_sh = ld_word[39:8];
      2'd2: ld_sh = ld_word[47:16];
      2'd3: ld_sh = ld_word[55:24];
      default: ld_sh = ld_word[31:0];
    endcase
    ld_result = ld_sh;
    case (op_f3)
      3'b000:  ld_result = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_result = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_result = {24'h0, ld_sh[7:0]};
      3'b101:  ld_result = {16'h0, ld_sh[15:0]};
      default: ld_result = ld_sh;
    endcase
    if (op_we) begin
      ld_result = '0;
    end
  end

  assign stall = (req_valid && (state == S_IDLE)) || ((state != S_IDLE) && (state != S_DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_we       <= 1'b0;
      op_f3       <= 3'b000;
      op_off      <= 2'b00;
      op_split    <= 1'b0;
      op_mask_hi  <= 4'h0;
      op_wdata_hi <= '0;
      op_addr1    <= '0;
      lo_q        <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_mask    <= 4'h0;
      rsp_valid   <= 1'b0;
      rdata       <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          rsp_valid <= 1'b0;
          err       <= 1'b0;
          if (req_valid) begin
            op_we       <= req_we;
            op_f3       <= func3;
            op_off      <= addr[1:0];
            op_split    <= in_split;
            op_mask_hi  <= in_mask[7:4];
            op_wdata_hi <= in_data[63:32];
            op_addr1    <= in_addr0 + 32'd4;
            if (in_legal) begin
              state     <= S_REQ0;
              bus_req   <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= in_addr0;
              bus_mask  <= in_mask[3:0];
              bus_wdata <= in_data[31:0];
            end else begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              err       <= 1'b1;
              rdata     <= '0;
            end
          end
        end
        S_REQ0: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= S_RSP0;
          end
        end
        S_RSP0: begin
          if (bus_rvalid) begin
            lo_q <= bus_rdata;
            if (op_split) begin
              state     <= S_REQ1;
              bus_req   <= 1'b1;
              bus_addr  <= op_addr1;
              bus_mask  <= op_mask_hi;
              bus_wdata <= op_wdata_hi;
            end else begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rdata     <= ld_result;
            end
          end
        end
        S_REQ1: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= S_RSP1;
          end
        end
        S_RSP1: begin
          if (bus_rvalid) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rdata     <= ld_result;
          end
        end
        S_DONE: begin
          // req_valid is still the completed instruction here; it is deliberately not re-accepted.
          rsp_valid <= 1'b0;
          err       <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: split-enabled instance for bus traffic, split-disabled instance for the error path.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        sel;

  logic        d_req_valid, n_req_valid;
  logic        d_stall, d_rsp_valid, d_err, d_bus_req, d_bus_we;
  logic [31:0] d_rdata, d_bus_addr, d_bus_wdata;
  logic [3:0]  d_bus_mask;
  logic        n_stall, n_rsp_valid, n_err, n_bus_req, n_bus_we;
  logic [31:0] n_rdata, n_bus_addr, n_bus_wdata;
  logic [3:0]  n_bus_mask;

  logic        o_stall, o_rsp_valid, o_err, o_bus_req, o_bus_we;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_mask;

  int checks = 0;
  int errors = 0;
  int nbeats, rsp_cyc, stall_cnt, stab_err;
  logic [31:0] got_rdata;
  logic        got_err;
  logic [31:0] b_addr [2];
  logic [31:0] b_wdata [2];
  logic [3:0]  b_mask [2];
  logic        b_we [2];

  always #5 clk = ~clk;

  assign d_req_valid = req_valid & ~sel;
  assign n_req_valid = req_valid & sel;

  assign o_stall     = sel ? n_stall     : d_stall;
  assign o_rsp_valid = sel ? n_rsp_valid : d_rsp_valid;
  assign o_err       = sel ? n_err       : d_err;
  assign o_rdata     = sel ? n_rdata     : d_rdata;
  assign o_bus_req   = sel ? n_bus_req   : d_bus_req;
  assign o_bus_we    = sel ? n_bus_we    : d_bus_we;
  assign o_bus_addr  = sel ? n_bus_addr  : d_bus_addr;
  assign o_bus_wdata = sel ? n_bus_wdata : d_bus_wdata;
  assign o_bus_mask  = sel ? n_bus_mask  : d_bus_mask;

  dmem_ctrl #(.DW(32), .SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(d_req_valid), .req_we(req_we), .func3(func3),
    .addr(addr), .wdata(wdata), .stall(d_stall), .rsp_valid(d_rsp_valid), .rdata(d_rdata),
    .err(d_err), .bus_req(d_bus_req), .bus_we(d_bus_we), .bus_addr(d_bus_addr),
    .bus_wdata(d_bus_wdata), .bus_mask(d_bus_mask), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  dmem_ctrl #(.DW(32), .SPLIT_EN(1'b0)) u_nosplit (
    .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_we(req_we), .func3(func3),
    .addr(addr), .wdata(wdata), .stall(n_stall), .rsp_valid(n_rsp_valid), .rdata(n_rdata),
    .err(n_err), .bus_req(n_bus_req), .bus_we(n_bus_we), .bus_addr(n_bus_addr),
    .bus_wdata(n_bus_wdata), .bus_mask(n_bus_mask), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Plays one op from just after a rising edge: memory grants after gd wait cycles and
  // returns each beat rd cycles after its grant; records beats, stall cycles and response.
  task automatic run_op(input logic s, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int gd, input int rd,
                        input logic [31:0] w0, input logic [31:0] w1);
    int req_wait = 0;
    int rwait = 0;
    bit pending = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    logic [3:0]  cur_mask = '0;
    logic        cur_we = 1'b0;
    sel = s; req_we = we; func3 = f3; addr = a; wdata = wd; req_valid = 1'b1;
    nbeats = 0; rsp_cyc = -1; stall_cnt = 0; stab_err = 0; got_rdata = '0; got_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_addr[i] = '0; b_wdata[i] = '0; b_mask[i] = '0; b_we[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 40 && rsp_cyc < 0; cyc++) begin
      @(negedge clk);
      bus_gnt = 1'b0;
      bus_rvalid = 1'b0;
      if (o_stall) stall_cnt++;
      if (o_rsp_valid) begin
        rsp_cyc = cyc; got_rdata = o_rdata; got_err = o_err;
      end else if (o_bus_req) begin
        if (req_wait == 0) begin
          cur_addr = o_bus_addr; cur_wdata = o_bus_wdata; cur_mask = o_bus_mask; cur_we = o_bus_we;
          if (nbeats < 2) begin
            b_addr[nbeats] = o_bus_addr; b_wdata[nbeats] = o_bus_wdata;
            b_mask[nbeats] = o_bus_mask; b_we[nbeats] = o_bus_we;
          end
        end else if (o_bus_addr !== cur_addr || o_bus_wdata !== cur_wdata ||
                     o_bus_mask !== cur_mask || o_bus_we !== cur_we) begin
          stab_err++;
        end
        if (req_wait == gd) begin
          bus_gnt = 1'b1; pending = 1'b1; rwait = 0; req_wait = 0; nbeats++;
        end else begin
          req_wait++;
        end
      end else if (pending) begin
        if (rwait == rd) begin
          bus_rvalid = 1'b1; bus_rdata = (nbeats == 1) ? w0 : w1; pending = 1'b0;
        end else begin
          rwait++;
        end
      end
    end
    // The pipeline advances after the completion cycle and drops the request.
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("no_reaccept", {61'h0, o_bus_req, o_rsp_valid, o_stall}, 64'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; func3 = 3'b000; addr = '0; wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {56'h0, d_bus_req, d_bus_we, d_rsp_valid, d_err, d_bus_mask}, 64'h0);
    chk("reset_bus", {d_bus_addr, d_bus_wdata}, 64'h0);
    chk("reset_rdata", {32'h0, d_rdata}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // LW aligned, zero wait
    run_op(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF, 32'h0);
    chk("lw_beats", 64'(nbeats), 64'd1);
    chk("lw_addr", {32'h0, b_addr[0]}, 64'h100);
    chk("lw_mask_we", {59'h0, b_mask[0], b_we[0]}, {59'h0, 4'b1111, 1'b0});
    chk("lw_rsp_cyc", 64'(rsp_cyc), 64'd3);
    chk("lw_rdata", {31'h0, got_err, got_rdata}, {31'h0, 1'b0, 32'hDEAD_BEEF});
    chk("lw_stall", 64'(stall_cnt), 64'd3);

    // LB / LBU top byte lane
    run_op(1'b0, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_1234, 32'h0);
    chk("lb_rdata", {32'h0, got_rdata}, 64'hFFFF_FF80);
    chk("lb_beat", {27'h0, nbeats[0], b_mask[0], b_addr[0]}, {27'h0, 1'b1, 4'b1000, 32'h100});
    run_op(1'b0, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_1234, 32'h0);
    chk("lbu_rdata", {32'h0, got_rdata}, 64'h0000_0080);
    chk("lbu_mask", {60'h0, b_mask[0]}, 64'h8);

    // SH upper half of a word
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 0, 0, 32'h1234_5678, 32'h0);
    chk("sh_beats", 64'(nbeats), 64'd1);
    chk("sh_bus", {b_addr[0], b_wdata[0]}, {32'h200, 32'hABCD_0000});
    chk("sh_mask_we", {59'h0, b_mask[0], b_we[0]}, {59'h0, 4'b1100, 1'b1});
    chk("sh_rsp", {31'h0, got_err, got_rdata}, 64'h0);
    chk("sh_rsp_cyc", 64'(rsp_cyc), 64'd3);

    // LW split across words
    run_op(1'b0, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'h4433_2211, 32'h8877_6655);
    chk("lws_beats", 64'(nbeats), 64'd2);
    chk("lws_addr", {b_addr[0], b_addr[1]}, {32'h100, 32'h104});
    chk("lws_mask", {56'h0, b_mask[0], b_mask[1]}, {56'h0, 4'b1110, 4'b0001});
    chk("lws_rdata", {32'h0, got_rdata}, 64'h5544_3322);
    chk("lws_rsp_cyc", 64'(rsp_cyc), 64'd5);
    chk("lws_stall", 64'(stall_cnt), 64'd5);

    // Split with address wrap
    run_op(1'b0, 1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0, 0, 0, 32'h4433_2211, 32'h8877_6655);
    chk("wrap_addr", {b_addr[0], b_addr[1]}, {32'hFFFF_FFFC, 32'h0000_0000});
    chk("wrap_rdata", {32'h0, got_rdata}, 64'h5544_3322);

    // SW split: lane-steered store data across both beats
    run_op(1'b0, 1'b1, 3'b010, 32'h0000_0103, 32'h1122_3344, 0, 0, 32'h0, 32'h0);
    chk("sws_wdata", {b_wdata[0], b_wdata[1]}, {32'h4400_0000, 32'h0011_2233});
    chk("sws_mask", {56'h0, b_mask[0], b_mask[1]}, {56'h0, 4'b1000, 4'b0111});
    chk("sws_addr1_we", {31'h0, b_we[1], b_addr[1]}, {31'h0, 1'b1, 32'h104});

    // Misaligned SW with splitting disabled
    run_op(1'b1, 1'b1, 3'b010, 32'h0000_0102, 32'h5555_AAAA, 0, 0, 32'h0, 32'h0);
    chk("ns_beats", 64'(nbeats), 64'd0);
    chk("ns_rsp", {31'h0, got_err, got_rdata}, {31'h0, 1'b1, 32'h0});
    chk("ns_rsp_cyc", 64'(rsp_cyc), 64'd1);
    chk("ns_stall", 64'(stall_cnt), 64'd1);

    // Illegal func3 011 and SBU-style store
    run_op(1'b0, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("f3_011", {30'h0, nbeats[1:0], got_err, 31'h0}, {30'h0, 2'b00, 1'b1, 31'h0});
    chk("f3_011_cyc", 64'(rsp_cyc), 64'd1);
    run_op(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("store_f3_100", {31'h0, got_err, 30'h0, nbeats[1:0]}, {31'h0, 1'b1, 32'h0});

    // LH with grant delayed 2 and response delayed 1
    run_op(1'b0, 1'b0, 3'b001, 32'h0000_0106, 32'h0, 2, 1, 32'hF00D_0000, 32'h0);
    chk("wait_stable", 64'(stab_err), 64'd0);
    chk("wait_beat", {28'h0, b_mask[0], b_addr[0]}, {28'h0, 4'b1100, 32'h104});
    chk("wait_rdata", {32'h0, got_rdata}, 64'hFFFF_F00D);
    chk("wait_rsp_cyc", 64'(rsp_cyc), 64'd6);

    // Reset asserted while waiting for the first beat's response
    sel = 1'b0; req_we = 1'b0; func3 = 3'b010; addr = 32'h0000_0300; wdata = '0; req_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_beat_req", {63'h0, o_bus_req}, 64'h1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("rst_gnt_drop", {62'h0, o_bus_req, o_stall}, 64'h1);
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctl", {55'h0, o_bus_req, o_bus_we, o_rsp_valid, o_err, o_bus_mask, o_stall}, 64'h0);
    chk("rst_mid_bus", {o_bus_addr, o_bus_wdata}, 64'h0);
    chk("rst_mid_rdata", {32'h0, o_rdata}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_abandon", {62'h0, o_bus_req, o_rsp_valid}, 64'h0);
    @(posedge clk);
    #1;
    run_op(1'b0, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 0, 0, 32'h0102_0304, 32'h0);
    chk("post_rst_lw", {32'h0, got_rdata}, 64'h0102_0304);
    chk("post_rst_cyc", {b_addr[0], 32'(rsp_cyc)}, {32'h104, 32'd3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Sequencing controller between the pipeline memory stage and a single-ported, word-organised data memory bus. It accepts one load or store at a time and drives a req/gnt/rvalid bus handshake, stalling the pipeline until the access completes. Misaligned halfword and word accesses are split into two aligned word beats, with byte-lane steering, masking and load extension handled internally. It sits in the MEM stage in place of a direct address/data connection to memory.

## Interface
Parameters:
- DW, 32, data/address width; only 32 supported.
- SPLIT_EN, 1, 1 = split misaligned accesses into two beats; 0 = flag them as errors with no bus access.

Ports:
- clk  in  1  clock; single clock domain, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  pipeline presents a memory op; held stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- func3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  DW  byte address (ALU result).
- wdata  in  DW  store data, right-aligned.
- stall  out  1  freeze pipeline.
- rsp_valid  out  1  one-cycle completion pulse.
- rdata  out  DW  extended load result, valid with rsp_valid.
- err  out  1  illegal func3 or misaligned with SPLIT_EN=0; valid with rsp_valid.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  DW  word-aligned address ([1:0]=00).
- bus_wdata  out  DW  lane-steered store data.
- bus_mask  out  4  byte-enable.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  beat complete (loads and stores); at most one per granted beat, never in the gnt cycle.
- bus_rdata  in  DW  read word, valid with bus_rvalid.

## Operation
- States: IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
- IDLE: when req_valid=1, register req_we, func3, addr, wdata. Legal → REQ0. Illegal (func3 011/110/111; stores with func3[2]=1; misaligned with SPLIT_EN=0) → DONE with err=1 and no bus activity.
- Lane math: o = addr[1:0], n = 1/2/4 bytes. 8-bit mask m = ((1<<n)-1)<<o. 64-bit data = wdata<<(8·o). Beat 0 uses m[3:0] and data[31:0] at {addr[31:2],00}. Split iff m[7:4]≠0; beat 1 uses m[7:4] and data[63:32] at beat-0 address + 4, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000).
- REQ0/REQ1: bus_req=1 with address, we, mask and wdata held stable until bus_gnt. On gnt → RSP0/RSP1.
- RSP0: on bus_rvalid, capture bus_rdata into the low buffer word; → REQ1 if split, else DONE. RSP1: on bus_rvalid, capture into the high word; → DONE.
- DONE: rsp_valid=1. For loads, rdata = ({hi,lo} >> 8·o)[n·8-1:0], sign-extended for B/H and zero-extended for BU/HU. For stores, rdata=0. Next state is always IDLE. A req_valid seen in DONE is the same instruction and is not re-accepted.
- Registered outputs: bus_*, rsp_valid, rdata, err. Combinational: stall = (req_valid & state==IDLE) | (state∉{IDLE,DONE}).
- Reset (synchronous, active-low, any state including mid-beat): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_mask=0, rsp_valid=0, rdata=0, err=0. Any outstanding bus beat is abandoned.

## Timing
- Aligned access with zero-wait memory (gnt in REQ cycle, rvalid the next cycle): req_valid seen in cycle 0, bus_req in cycle 1, rvalid in cycle 2, rsp_valid in cycle 3. The pipeline stalls for 3 cycles.
- Split access adds 2 cycles (rsp_valid in cycle 5 minimum).
- Illegal access: rsp_valid+err in cycle 1, stalling 1 cycle.
- Each gnt wait cycle or rvalid wait cycle adds one cycle. There is no timeout.
- bus_req deasserts in the cycle after gnt. The controller never has more than one beat outstanding.

## Test plan
- LW addr 0x100, bus_rdata 0xDEADBEEF, zero wait → bus_addr 0x100, mask 1111; rsp_valid in cycle 3 with rdata 0xDEADBEEF; stall high for exactly 3 cycles.
- LB addr 0x103 and LBU addr 0x103, memory word 0x80FF_1234 → rdata 0xFFFFFF80 and 0x00000080 respectively; single beat, mask 1000.
- SH addr 0x202, wdata 0x0000ABCD → one beat: bus_addr 0x200, mask 1100, bus_wdata 0xABCD0000, bus_we=1; rdata 0, err 0.
- LW addr 0x101 split, words 0x44332211 @0x100 and 0x88776655 @0x104 → two beats with masks 1110 then 0001; rdata 0x55443322; rsp_valid in cycle 5. Same access at 0xFFFFFFFD → second beat bus_addr 0x00000000.
- SW addr 0x102 with SPLIT_EN=0, and func3 011 → no bus_req; rsp_valid+err in cycle 1.
- gnt delayed 2 cycles then rsp delayed 1 cycle: bus signals stay stable while waiting. Assert rst_n=0 during RSP0 → next cycle IDLE with all outputs 0, and a fresh LW completes normally.
